// File: rtl/sudp_bus_pkg.sv
// Shared types and widths for the SU datapath readback-bus driver.
// Included by sudp_bus_fifo and sudp_bus_ctl.
package sudp_bus_pkg;

    localparam int DATA_W  = 32;
    localparam int BURST_W = 8;
    localparam int TURN_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETUP   = 3'd2,
        ST_DRIVE   = 3'd3,
        ST_RELEASE = 3'd4
    } busState_e;

    function automatic int ptrWidth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sudp_bus_fifo.sv
// DEPTH x 32 register FIFO holding producer words until they are driven on the bus.
// A push while full is dropped even if a pop happens in the same cycle.
module sudp_bus_fifo
    import sudp_bus_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic              clk,
    input  logic              reset_l,
    input  logic              push_i,
    input  logic [DATA_W-1:0] pushData_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = ptrWidth(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              doPush;
    logic              doPop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO through the pointers and count.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/sudp_bus_ctl.sv
// Readback-bus driver: FIFO, bus request/grant FSM, burst limit and turnaround.
// Define SUDP_BUS_PARITY_EN to add the registered even-parity output bus_par.
module sudp_bus_ctl
    import sudp_bus_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MAX_BURST   = 8,
    parameter int TURN_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              reset_l,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_en,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_strobe
`ifdef SUDP_BUS_PARITY_EN
    ,
    output logic              bus_par
`endif
);

    localparam logic [BURST_W-1:0] MAX_B     = BURST_W'(MAX_BURST);
    localparam logic [TURN_W-1:0]  TURN_LAST = TURN_W'(TURN_CYCLES - 1);

    busState_e          state_q;
    logic [BURST_W-1:0] burst_q;
    logic [TURN_W-1:0]  turn_q;
    logic               req_q;
    logic               en_q;
    logic               strobe_q;
    logic [DATA_W-1:0]  data_q;

    logic [DATA_W-1:0]  fifoHead;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               fifoPop;
    logic               driveGo;
    logic               loadData;

    sudp_bus_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk        (clk),
        .reset_l    (reset_l),
        .push_i     (wr_valid),
        .pushData_i (wr_data),
        .pop_i      (fifoPop),
        .head_o     (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // The word on the bus is popped at the edge that loads it, so DRIVE keeps going only
    // while another word is queued, the burst has room and the grant is still held.
    assign driveGo  = (state_q == ST_DRIVE) && !fifoEmpty && (burst_q != MAX_B) && bus_gnt;
    assign fifoPop  = (state_q == ST_SETUP) || driveGo;
    assign loadData = ((state_q == ST_REQ) && bus_gnt) || fifoPop;
    assign wr_ready = !fifoFull;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= ST_IDLE;
            burst_q  <= '0;
            turn_q   <= '0;
            req_q    <= 1'b0;
            en_q     <= 1'b0;
            strobe_q <= 1'b0;
            data_q   <= '0;
        end else begin
            if (loadData) data_q <= fifoHead;
            case (state_q)
                ST_IDLE: begin
                    if (!fifoEmpty) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        state_q <= ST_SETUP;
                        en_q    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q  <= ST_DRIVE;
                    strobe_q <= 1'b1;
                    burst_q  <= 8'd1;
                end
                ST_DRIVE: begin
                    if (driveGo) begin
                        burst_q <= burst_q + 8'd1;
                    end else begin
                        state_q  <= ST_RELEASE;
                        req_q    <= 1'b0;
                        en_q     <= 1'b0;
                        strobe_q <= 1'b0;
                        burst_q  <= '0;
                        turn_q   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (turn_q == TURN_LAST) state_q <= ST_IDLE;
                    else                     turn_q  <= turn_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_req    = req_q;
    assign bus_en     = en_q;
    assign bus_strobe = strobe_q;
    assign bus_data   = data_q;

`ifdef SUDP_BUS_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)      par_q <= 1'b0;
        else if (loadData) par_q <= ^fifoHead;
    end

    assign bus_par = par_q;
`endif

endmodule

// File: tb/tb_sudp_bus_ctl.sv
// Scoreboard bench for sudp_bus_ctl: accepted words are queued, a negedge monitor
// checks every strobe against the queue plus burst-length and turnaround rules.
module tb_sudp_bus_ctl;

    localparam int DEPTH       = 4;
    localparam int MAX_BURST   = 3;
    localparam int TURN_CYCLES = 2;

    logic        clk      = 1'b0;
    logic        reset_l  = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data  = '0;
    logic        bus_gnt  = 1'b0;
    logic        wr_ready;
    logic        bus_req;
    logic        bus_en;
    logic [31:0] bus_data;
    logic        bus_strobe;
`ifdef SUDP_BUS_PARITY_EN
    logic        bus_par;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];
    int          burstLens[$];

    sudp_bus_ctl #(
        .DEPTH       (DEPTH),
        .MAX_BURST   (MAX_BURST),
        .TURN_CYCLES (TURN_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_en     (bus_en),
        .bus_data   (bus_data),
        .bus_strobe (bus_strobe)
`ifdef SUDP_BUS_PARITY_EN
        ,
        .bus_par    (bus_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic flagFail(input string name, input int actual, input int expected);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold wr_valid until the FIFO takes the word, recording it as the next expected strobe.
    task automatic applyStimulus(input logic [31:0] data, input int budget);
        int waited = 0;
        wr_valid = 1'b1;
        wr_data  = data;
        while (!wr_ready && waited < budget) begin
            tick();
            waited++;
        end
        if (wr_ready) begin
            expQ.push_back(data);
            tick();
        end else begin
            flagFail("push_timeout", waited, budget);
        end
        wr_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int waited = 0;
        while ((expQ.size() != 0 || bus_en) && waited < budget) begin
            tick();
            waited++;
        end
        checks++;
        if (expQ.size() != 0 || bus_en) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d words still pending, en=%0b", expQ.size(), bus_en);
        end
        repeat (TURN_CYCLES + 2) tick();
    endtask

    task automatic waitStrobe(input int budget);
        int waited = 0;
        while (!bus_strobe && waited < budget) begin
            tick();
            waited++;
        end
        if (!bus_strobe) flagFail("strobe_timeout", waited, budget);
    endtask

    task automatic checkBursts(input string name, input int first, input int second);
        checkOutput({name, "_count"}, burstLens.size(), 2);
        if (burstLens.size() >= 2) begin
            checkOutput({name, "_len0"}, burstLens[0], first);
            checkOutput({name, "_len1"}, burstLens[1], second);
        end
    endtask

    // Monitor: every strobe must carry the oldest accepted word, bursts stay within MAX_BURST,
    // and bus_req stays low for TURN_CYCLES samples after bus_en falls.
    logic        prevEn = 1'b0;
    int          burstCnt = 0;
    int          turnLeft = 0;
    logic [31:0] expWord;

    always @(negedge clk) begin
        if (bus_strobe) begin
            checkOutput("strobe_with_en", bus_en, 1);
            if (expQ.size() == 0) begin
                flagFail("unexpected_strobe", 1, 0);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("bus_data", bus_data, expWord);
`ifdef SUDP_BUS_PARITY_EN
                checkOutput("bus_par", bus_par, ^expWord);
`endif
            end
            burstCnt++;
            if (burstCnt > MAX_BURST) flagFail("burst_limit", burstCnt, MAX_BURST);
        end
        if (prevEn && !bus_en) begin
            burstLens.push_back(burstCnt);
            burstCnt = 0;
            turnLeft = TURN_CYCLES;
        end
        if (turnLeft > 0) begin
            checkOutput("turnaround_req", bus_req, 0);
            turnLeft--;
        end
        prevEn = bus_en;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 reset_l = 1'b0;
        #11;
        checkOutput("rst_req", bus_req, 0);
        checkOutput("rst_en", bus_en, 0);
        checkOutput("rst_strobe", bus_strobe, 0);
        checkOutput("rst_data", bus_data, 32'h0);
`ifdef SUDP_BUS_PARITY_EN
        checkOutput("rst_par", bus_par, 0);
`endif
        @(negedge clk);
        reset_l = 1'b1;
        tick();
        checkOutput("rst_wr_ready", wr_ready, 1);

        $display("[TB] single word with grant tied high");
        bus_gnt  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'hDEADBEEF;
        expQ.push_back(32'hDEADBEEF);
        tick();
        wr_valid = 1'b0;
        checkOutput("t1_req_p0", bus_req, 0);
        tick();
        checkOutput("t1_req_p1", bus_req, 1);
        checkOutput("t1_en_p1", bus_en, 0);
        tick();
        checkOutput("t1_en_p2", bus_en, 1);
        checkOutput("t1_strobe_p2", bus_strobe, 0);
        tick();
        checkOutput("t1_strobe_p3", bus_strobe, 1);
        checkOutput("t1_data_p3", bus_data, 32'hDEADBEEF);
        tick();
        checkOutput("t1_en_p4", bus_en, 0);
        checkOutput("t1_strobe_p4", bus_strobe, 0);
        checkOutput("t1_req_p4", bus_req, 0);
        checkOutput("t1_data_hold_p4", bus_data, 32'hDEADBEEF);
        waitDrain(20);

        $display("[TB] fill FIFO with grant low, fifth word held");
        bus_gnt = 1'b0;
        burstLens.delete();
        for (int k = 0; k < DEPTH; k++) applyStimulus(32'hA000_0000 + k, 10);
        checkOutput("t2_full_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 32'hA000_0004;
        repeat (3) begin
            tick();
            checkOutput("t2_hold_ready", wr_ready, 0);
            checkOutput("t2_wait_req", bus_req, 1);
            checkOutput("t2_wait_en", bus_en, 0);
        end
        bus_gnt = 1'b1;
        applyStimulus(32'hA000_0004, 20);
        waitDrain(60);
        checkBursts("t2_bursts", 3, 2);

        $display("[TB] burst limit with four queued words");
        bus_gnt = 1'b0;
        burstLens.delete();
        for (int k = 0; k < DEPTH; k++) applyStimulus(32'hB000_0000 + k, 10);
        bus_gnt = 1'b1;
        waitDrain(60);
        checkBursts("t3_bursts", 3, 1);

        $display("[TB] grant drop in second drive cycle");
        bus_gnt = 1'b0;
        burstLens.delete();
        for (int k = 0; k < DEPTH; k++) applyStimulus(32'hC000_0000 + k, 10);
        bus_gnt = 1'b1;
        waitStrobe(20);
        tick();
        checkOutput("t4_second_strobe", bus_strobe, 1);
        bus_gnt = 1'b0;
        tick();
        checkOutput("t4_en_drop", bus_en, 0);
        checkOutput("t4_strobe_drop", bus_strobe, 0);
        begin
            int waited = 0;
            while (!bus_req && waited < 20) begin
                tick();
                waited++;
            end
            checkOutput("t4_req_again", bus_req, 1);
            checkOutput("t4_en_wait", bus_en, 0);
        end
        bus_gnt = 1'b1;
        waitDrain(60);
        checkBursts("t4_bursts", 2, 2);

        $display("[TB] asynchronous reset during a strobe");
        bus_gnt = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(32'hD000_0000 + k, 10);
        bus_gnt = 1'b1;
        waitStrobe(20);
        #2 reset_l = 1'b0;
        #1;
        checkOutput("t5_en_async", bus_en, 0);
        checkOutput("t5_strobe_async", bus_strobe, 0);
        checkOutput("t5_req_async", bus_req, 0);
        checkOutput("t5_ready_flushed", wr_ready, 1);
        expQ.delete();
        @(negedge clk);
        reset_l = 1'b1;
        repeat (3) tick();
        burstLens.delete();
        checkOutput("t5_idle_req", bus_req, 0);
        applyStimulus(32'h1234_5678, 10);
        waitDrain(30);
        checkOutput("t5_one_burst", burstLens.size(), 1);

        $display("[TB] parity words");
        applyStimulus(32'h0000_0001, 10);
        applyStimulus(32'h0000_0003, 10);
        waitDrain(30);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            bus_gnt  = ($urandom_range(0, 3) != 0);
            if (wr_valid && wr_ready) expQ.push_back(wr_data);
            tick();
        end
        wr_valid = 1'b0;
        bus_gnt  = 1'b1;
        waitDrain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
